// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, in-order
// response buffering with PC tags, and redirect flush with response discard.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] out_next;
  logic [CW:0]   credit;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic          misalign_q;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;
  logic [31:0]   tgt;

  assign cnt    = wptr - rptr;
  assign credit = {1'b0, outstanding} + {1'b0, cnt};
  assign tgt    = {redirect_pc_i[31:2], 2'b00};

  // Credit covers in-flight plus buffered words, so the FIFO cannot overflow
  assign imem_req_o  = (state != BOOT) && !redirect_i
                     && (credit < (CW+1)'(DEPTH));
  assign imem_addr_o = fpc;

  assign grant = imem_req_o && imem_gnt_i;
  assign drop  = imem_rvalid_i && (discard != '0);
  assign push  = imem_rvalid_i && (discard == '0) && !redirect_i;
  assign pop   = inst_valid_o && inst_ready_i && !redirect_i;

  assign out_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);

  assign inst_valid_o = (wptr != rptr);
  assign inst_o       = mem_inst[rptr[AW-1:0]];
  assign inst_pc_o    = mem_pc[rptr[AW-1:0]];
  assign misalign_o   = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      wptr        <= '0;
      rptr        <= '0;
      misalign_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      outstanding <= out_next;
      misalign_q  <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i) begin
        fpc     <= tgt;
        rpc     <= tgt;
        wptr    <= '0;
        rptr    <= '0;
        discard <= out_next;
        state   <= (out_next != '0) ? DRAIN : RUN;
      end else begin
        if (grant) fpc <= fpc + 32'd4;
        if (drop) discard <= discard - CW'(1);
        if (push) begin
          mem_inst[wptr[AW-1:0]] <= imem_rdata_i;
          mem_pc[wptr[AW-1:0]]   <= rpc;
          wptr <= wptr + CW'(1);
          rpc  <= rpc + 32'd4;
        end
        if (pop) rptr <= rptr + CW'(1);
        unique case (state)
          BOOT:  state <= RUN;
          RUN:   state <= RUN;
          DRAIN: begin
            if (discard == '0 || (drop && discard == CW'(1)))
              state <= RUN;
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder plus a queue-based
// model of the fetch stream, with directed and randomized scenarios.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;
  logic        misalign_o;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i),
    .misalign_o   (misalign_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] pending [$];
  logic [31:0] fifo_q [$];
  logic [31:0] m_fpc, m_rpc;
  int          m_disc;
  bit          m_boot, m_mis;

  logic        obs_req, obs_valid, obs_mis;
  logic [31:0] obs_addr, obs_pc, obs_inst;
  logic        exp_req, exp_valid, exp_mis;
  logic [31:0] exp_addr, exp_pc, exp_inst;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    pending.delete();
    fifo_q.delete();
    m_fpc  = RPC;
    m_rpc  = RPC;
    m_disc = 0;
    m_boot = 1'b1;
    m_mis  = 1'b0;
  endtask

  task automatic drive_idle();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle: drive, sample, predict, then advance model across the edge
  task automatic step(input bit g, input bit rv, input bit rdy,
                      input bit rd, input logic [31:0] tpc);
    bit          rvh;
    logic [31:0] t;
    @(negedge clk);
    rvh = rv && (pending.size() != 0);
    imem_gnt_i    = g;
    imem_rvalid_i = rvh;
    imem_rdata_i  = rvh ? word(pending[0]) : $urandom;
    inst_ready_i  = rdy;
    redirect_i    = rd;
    redirect_pc_i = tpc;
    #1;
    obs_req   = imem_req_o;
    obs_addr  = imem_addr_o;
    obs_valid = inst_valid_o;
    obs_pc    = inst_pc_o;
    obs_inst  = inst_o;
    obs_mis   = misalign_o;
    exp_req   = !m_boot && !rd && (pending.size() + fifo_q.size() < DEPTH);
    exp_addr  = m_fpc;
    exp_valid = (fifo_q.size() != 0);
    exp_pc    = exp_valid ? fifo_q[0] : '0;
    exp_inst  = word(exp_pc);
    exp_mis   = m_mis;
    @(posedge clk);
    if (rd) begin
      if (rvh) void'(pending.pop_front());
      fifo_q.delete();
      m_disc = pending.size();
      t = {tpc[31:2], 2'b00};
      m_fpc = t;
      m_rpc = t;
    end else begin
      if (rdy && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (rvh) begin
        void'(pending.pop_front());
        if (m_disc > 0) m_disc--;
        else begin
          fifo_q.push_back(m_rpc);
          m_rpc += 32'd4;
        end
      end
      if (obs_req && g) begin
        pending.push_back(obs_addr);
        m_fpc += 32'd4;
      end
    end
    m_mis  = rd && (tpc[1:0] != 2'b00);
    m_boot = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    #3;
    n_chk++; if (imem_req_o !== 1'b0) $display("FAIL rst_req got %0b want 0", imem_req_o); else n_pass++;
    n_chk++; if (imem_addr_o !== RPC) $display("FAIL rst_addr got %h want %h", imem_addr_o, RPC); else n_pass++;
    n_chk++; if (inst_valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", inst_valid_o); else n_pass++;
    n_chk++; if (inst_o !== 32'h0) $display("FAIL rst_inst got %h want 0", inst_o); else n_pass++;
    n_chk++; if (inst_pc_o !== 32'h0) $display("FAIL rst_pc got %h want 0", inst_pc_o); else n_pass++;
    n_chk++; if (misalign_o !== 1'b0) $display("FAIL rst_mis got %0b want 0", misalign_o); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_stream();
    int first = -1;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      step(1, 1, 1, 0, '0);
      if (i >= 2 && i <= 4) begin
        n_chk++;
        if (obs_req !== 1'b1 || obs_addr !== 32'((i - 2) * 4))
          $display("FAIL stream_addr%0d got req=%0b addr=%h want req=1 addr=%h", i, obs_req, obs_addr, (i - 2) * 4);
        else n_pass++;
      end
      if (obs_valid && first < 0) begin
        first = i;
        n_chk++; if (obs_pc !== RPC) $display("FAIL stream_first_pc got %h want %h", obs_pc, RPC); else n_pass++;
      end
      if (exp_valid) begin
        n_chk++; if (obs_pc !== exp_pc) $display("FAIL stream_pc got %h want %h", obs_pc, exp_pc); else n_pass++;
        n_chk++; if (obs_inst !== exp_inst) $display("FAIL stream_inst got %h want %h", obs_inst, exp_inst); else n_pass++;
      end
    end
    n_chk++; if (first !== 4) $display("FAIL stream_latency got step %0d want step 4", first); else n_pass++;
  endtask

  task automatic test_backpressure();
    int grants = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, '0);
      if (obs_req) grants++;
    end
    n_chk++; if (grants !== 4) $display("FAIL bp_grants got %0d want 4", grants); else n_pass++;
    n_chk++; if (obs_req !== 1'b0) $display("FAIL bp_req_full got %0b want 0", obs_req); else n_pass++;
    step(1, 1, 1, 0, '0);
    n_chk++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) $display("FAIL bp_head got v=%0b pc=%h want v=1 pc=0", obs_valid, obs_pc); else n_pass++;
    step(1, 1, 1, 0, '0);
    n_chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h10) $display("FAIL bp_next got req=%0b addr=%h want req=1 addr=10", obs_req, obs_addr); else n_pass++;
  endtask

  task automatic test_gnt_stall();
    do_reset();
    step(1, 1, 1, 0, '0);
    step(1, 1, 1, 0, '0);
    step(1, 1, 1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, '0);
      n_chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) $display("FAIL stall_hold%0d got req=%0b addr=%h want req=1 addr=8", i, obs_req, obs_addr); else n_pass++;
    end
    step(1, 1, 1, 0, '0);
    n_chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) $display("FAIL stall_grant got req=%0b addr=%h want req=1 addr=8", obs_req, obs_addr); else n_pass++;
    step(1, 1, 1, 0, '0);
    n_chk++; if (obs_addr !== 32'hC) $display("FAIL stall_next got addr=%h want C", obs_addr); else n_pass++;
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    do_reset();
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 1, 32'h100);
    n_chk++; if (obs_req !== 1'b0) $display("FAIL redir_req got %0b want 0", obs_req); else n_pass++;
    step(0, 1, 0, 0, '0);
    n_chk++; if (obs_valid !== 1'b0) $display("FAIL redir_flush got %0b want 0", obs_valid); else n_pass++;
    n_chk++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) $display("FAIL redir_addr got req=%0b addr=%h want req=1 addr=100", obs_req, obs_addr); else n_pass++;
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1, 1, 1, 0, '0);
      if (obs_valid) begin
        seen = 1'b1;
        n_chk++; if (obs_pc !== 32'h100 || obs_inst !== word(32'h100)) $display("FAIL redir_first got pc=%h inst=%h want pc=100 inst=%h", obs_pc, obs_inst, word(32'h100)); else n_pass++;
      end
    end
    if (!seen) begin n_chk++; $display("FAIL redir_timeout got no valid want valid"); end
  endtask

  task automatic test_misalign();
    bit seen = 1'b0;
    do_reset();
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    step(0, 1, 1, 1, 32'h102);
    step(0, 0, 0, 0, '0);
    n_chk++; if (obs_mis !== 1'b1) $display("FAIL mis_pulse got %0b want 1", obs_mis); else n_pass++;
    n_chk++; if (obs_valid !== 1'b0) $display("FAIL mis_flush got %0b want 0", obs_valid); else n_pass++;
    n_chk++; if (obs_addr !== 32'h100) $display("FAIL mis_addr got %h want 100", obs_addr); else n_pass++;
    step(0, 1, 0, 0, '0);
    n_chk++; if (obs_mis !== 1'b0) $display("FAIL mis_clear got %0b want 0", obs_mis); else n_pass++;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1, 1, 1, 0, '0);
      if (obs_valid) begin
        seen = 1'b1;
        n_chk++; if (obs_pc !== 32'h100 || obs_inst !== word(32'h100)) $display("FAIL mis_first got pc=%h inst=%h want pc=100 inst=%h", obs_pc, obs_inst, word(32'h100)); else n_pass++;
      end
    end
    if (!seen) begin n_chk++; $display("FAIL mis_timeout got no valid want valid"); end
  endtask

  task automatic test_async_reset();
    bit first = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, '0);
    n_chk++; if (inst_valid_o !== 1'b1) $display("FAIL ar_prefill got %0b want 1", inst_valid_o); else n_pass++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (inst_valid_o !== 1'b0) $display("FAIL ar_valid got %0b want 0", inst_valid_o); else n_pass++;
    n_chk++; if (imem_req_o !== 1'b0) $display("FAIL ar_req got %0b want 0", imem_req_o); else n_pass++;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1, 0, '0);
      if (i == 1) begin
        n_chk++; if (obs_addr !== RPC) $display("FAIL ar_restart got %h want %h", obs_addr, RPC); else n_pass++;
      end
      n_chk++; if (obs_valid !== exp_valid) $display("FAIL ar_model_valid got %0b want %0b", obs_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_chk++; if (obs_pc !== exp_pc) $display("FAIL ar_model_pc got %h want %h", obs_pc, exp_pc); else n_pass++;
        if (first) begin
          first = 1'b0;
          n_chk++; if (obs_pc !== RPC) $display("FAIL ar_first_pc got %h want %h", obs_pc, RPC); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_random();
    bit          g, rv, rdy, rd;
    logic [31:0] tpc;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      g   = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 99) < 3);
      tpc = $urandom & 32'h0000_3FFF;
      step(g, rv, rdy, rd, tpc);
      n_chk++; if (obs_req !== exp_req) $display("FAIL rnd_req @%0d got %0b want %0b", i, obs_req, exp_req); else n_pass++;
      if (exp_req) begin
        n_chk++; if (obs_addr !== exp_addr) $display("FAIL rnd_addr @%0d got %h want %h", i, obs_addr, exp_addr); else n_pass++;
      end
      n_chk++; if (obs_valid !== exp_valid) $display("FAIL rnd_valid @%0d got %0b want %0b", i, obs_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_chk++; if (obs_pc !== exp_pc) $display("FAIL rnd_pc @%0d got %h want %h", i, obs_pc, exp_pc); else n_pass++;
        n_chk++; if (obs_inst !== exp_inst) $display("FAIL rnd_inst @%0d got %h want %h", i, obs_inst, exp_inst); else n_pass++;
      end
      n_chk++; if (obs_mis !== exp_mis) $display("FAIL rnd_mis @%0d got %0b want %0b", i, obs_mis, exp_mis); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_misalign();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that feeds the decode/control path of the riscv core; sits between instruction memory and the instruction consumer.
- Generates sequential fetch addresses, issues requests to instruction memory with a req/gnt/rvalid handshake, and buffers returned words with their PCs in a prefetch FIFO.
- Presents one instruction per cycle to decode via valid/ready.
- Accepts branch/jump redirects, flushing buffered and in-flight instructions.

Parameters:
- DEPTH, 4: prefetch FIFO entries; also the maximum of outstanding requests plus buffered entries. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid; responses return in request order, at least 1 cycle after gnt
- imem_rdata_i  in  32  instruction word
- redirect_i  in  1  branch/jump taken, flush and refetch
- redirect_pc_i  in  32  new fetch address
- inst_valid_o  out  1  FIFO head valid
- inst_o  out  32  instruction at FIFO head
- inst_pc_o  out  32  PC of inst_o
- inst_ready_i  in  1  consumer accepts head
- misalign_o  out  1  one-cycle pulse: redirect_pc_i[1:0] was nonzero

Behaviour:
- Reset, asynchronous:
  - fpc = RESET_PC, rpc = RESET_PC, outstanding = 0, discard = 0, FIFO empty, FSM = BOOT.
  - All outputs 0, except imem_addr_o = RESET_PC.
- FSM:
  - BOOT: req low for one cycle, then RUN.
  - RUN: normal fetch.
  - DRAIN: entered on a redirect when discard_next > 0; returns to RUN when discard reaches 0.
  - Requests are allowed in both RUN and DRAIN.
- Request issue:
  - imem_req_o = 1 when FSM != BOOT, redirect_i = 0, and (outstanding + fifo_count) < DEPTH. This credit rule guarantees the FIFO never overflows.
  - imem_addr_o = fpc.
  - Once raised, req and addr stay stable until gnt. The only exception is redirect_i, which withdraws req combinationally in that cycle.
  - On req & gnt: fpc += 4 (wraps mod 2^32); outstanding += 1.
- Responses:
  - Each rvalid decrements outstanding.
  - If discard > 0: the response is dropped and discard -= 1.
  - Otherwise: push {imem_rdata_i, rpc} into the FIFO and rpc += 4.
  - Latency from rvalid to inst_valid_o is 1 cycle; there is no bypass.
- Output:
  - inst_valid_o = FIFO not empty; inst_o and inst_pc_o come from the head.
  - Pop on inst_valid_o & inst_ready_i.
  - Push and pop in the same cycle is legal at any occupancy.
- Redirect (priority over all other events in the cycle):
  - FIFO flushed; any pop or push this cycle is ignored.
  - fpc and rpc = {redirect_pc_i[31:2], 2'b00}.
  - misalign_o = 1 next cycle if redirect_pc_i[1:0] != 0.
  - discard_next = outstanding (including a gnt this cycle, which cannot occur since req is withdrawn) minus 1 if rvalid is high this cycle. That rvalid is dropped.
  - inst_valid_o = 0 the cycle after a redirect.
  - Back-to-back redirects: each recomputes discard from the current outstanding count; the last one wins.
- Counters: outstanding is clog2(DEPTH)+1 bits wide and saturates at neither end. An rvalid with outstanding = 0 is a protocol violation; assert it in simulation.

Test Plan:
- Reset; gnt = 1 always; rvalid 1 cycle after gnt; ready = 1 → addr 0x0, 0x4, 0x8 on consecutive cycles. inst_valid_o first high 3 cycles after reset release, with inst_pc_o = 0x0, then one instruction per cycle with PC incrementing by 4.
- As above but ready = 0 → exactly 4 grants (0x0–0xC), then req low with FIFO full. Raise ready → head pc 0x0 pops and the next request is addr 0x10.
- Hold gnt = 0 for 3 cycles while req is high at 0x8 → req and addr 0x8 stay stable. Grant on cycle 4 → next addr 0xC.
- Redirect to 0x100 with 2 requests outstanding and 1 buffered → FIFO empties. The next 2 rvalids are dropped. The first delivered instruction has inst_pc_o = 0x100, and the first post-redirect request addr = 0x100.
- Redirect to 0x102 → fetch addr 0x100 and a one-cycle misalign_o pulse. Redirect with simultaneous rvalid and pop → both ignored and discard = outstanding - 1.
- Assert rst asynchronously mid-stream, between clock edges → inst_valid_o and imem_req_o drop to 0 immediately. After release, fetch restarts at RESET_PC with no stale instruction delivered.
